// File: rtl/stepper_pkg.sv
// Shared types and constants for the bipolar stepper sequencer.
// Coil nibble ordering is {B-, A-, B+, A+}.
package stepper_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int COIL_A_POS  = 0;
   localparam int COIL_BP_POS = 1;
   localparam int COIL_AN_POS = 2;
   localparam int COIL_BN_POS = 3;
   localparam int COIL_W      = 4;

   // Half-step table: even entries energise one winding, odd entries two.
   localparam logic [7:0][COIL_W-1:0] PHASE_TABLE = {
      4'b1001, 4'b1000, 4'b1100, 4'b0100,
      4'b0110, 4'b0010, 4'b0011, 4'b0001
   };

   function automatic logic [2:0] next_phase(input logic [2:0] cur,
                                             input logic       fwd,
                                             input logic       half);
      logic [2:0] delta;
      delta = half ? 3'd1 : 3'd2;
      return fwd ? cur + delta : cur - delta;
   endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running duty counter; pwm_on is high while the count is below duty.
module pwm_gen #(
   parameter int DUTY_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DUTY_W-1:0] duty,
   output logic              pwm_on
);

   logic [DUTY_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign pwm_on = (cnt_q < duty);

endmodule

// File: rtl/step_sequencer.sv
// Bipolar stepper sequencer: accepts a move, walks the phase table at the
// programmed rate. Optional coil chopping when STEPPER_PWM_EN is defined.
import stepper_pkg::*;

module step_sequencer #(
   parameter int PERIOD_W = 16,
   parameter int COUNT_W  = 16,
   parameter int DUTY_W   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [COUNT_W-1:0]  steps,
   input  logic [PERIOD_W-1:0] period,
   input  logic                dir,
   input  logic                half_step,
   input  logic                abort,
   input  logic                hold,
   input  logic [DUTY_W-1:0]   duty,
   output logic                ready,
   output logic                busy,
   output logic                done,
   output logic [COUNT_W-1:0]  remaining,
   output logic [2:0]          phase,
   output logic [3:0]          coil
);

   localparam logic [PERIOD_W-1:0] PERIOD_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
   localparam logic [COUNT_W-1:0]  COUNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] tick_q, tick_d;
   logic [COUNT_W-1:0]  remaining_q, remaining_d;
   logic [2:0]          phase_q, phase_d;
   logic                dir_q, dir_d;
   logic                half_q, half_d;
   logic                done_q, done_d;
   logic [COIL_W-1:0]   coil_q, coil_d;
   logic [COIL_W-1:0]   table_val;
   logic                pwm_on;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         period_q    <= PERIOD_ONE;
         tick_q      <= '0;
         remaining_q <= '0;
         phase_q     <= '0;
         dir_q       <= 1'b0;
         half_q      <= 1'b0;
         done_q      <= 1'b0;
         coil_q      <= '0;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         tick_q      <= tick_d;
         remaining_q <= remaining_d;
         phase_q     <= phase_d;
         dir_q       <= dir_d;
         half_q      <= half_d;
         done_q      <= done_d;
         coil_q      <= coil_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      period_d    = period_q;
      tick_d      = tick_q;
      remaining_d = remaining_q;
      phase_d     = phase_q;
      dir_d       = dir_q;
      half_d      = half_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && (steps != '0)) begin
               state_d     = ST_RUN;
               dir_d       = dir;
               half_d      = half_step;
               period_d    = (period == '0) ? PERIOD_ONE : period;
               tick_d      = period_d - PERIOD_ONE;
               remaining_d = steps;
            end
         end
         ST_RUN: begin
            // Abort beats a coincident step: phase and remaining stay put.
            if (abort) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (tick_q == '0) begin
               phase_d     = next_phase(phase_q, dir_q, half_q);
               remaining_d = remaining_q - COUNT_ONE;
               tick_d      = period_q - PERIOD_ONE;
               if (remaining_q == COUNT_ONE) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               tick_d = tick_q - PERIOD_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef STEPPER_PWM_EN
   pwm_gen #(.DUTY_W(DUTY_W)) u_pwm (
      .clk    (clk),
      .rst_n  (rst_n),
      .duty   (duty),
      .pwm_on (pwm_on)
   );
`else
   logic unused_duty;
   assign unused_duty = ^duty;
   assign pwm_on      = 1'b1;
`endif

   assign table_val = ((state_q == ST_RUN) || hold) ? PHASE_TABLE[phase_q] : '0;

   for (genvar gi = 0; gi < COIL_W; gi++) begin : g_coil
      assign coil_d[gi] = table_val[gi] & pwm_on;
   end

   assign ready     = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_RUN);
   assign done      = done_q;
   assign remaining = remaining_q;
   assign phase     = phase_q;
   assign coil      = coil_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: directed moves plus randomized
// moves compared every cycle against a move-level reference model.
`timescale 1ns/1ps
module tb_step_sequencer;

   localparam int PERIOD_W = 16;
   localparam int COUNT_W  = 16;
   localparam int DUTY_W   = 8;
`ifdef STEPPER_PWM_EN
   localparam bit PWM = 1'b1;
`else
   localparam bit PWM = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic                start = 1'b0;
   logic [COUNT_W-1:0]  steps = '0;
   logic [PERIOD_W-1:0] period = '0;
   logic                dir = 1'b0;
   logic                half_step = 1'b0;
   logic                abort = 1'b0;
   logic                hold = 1'b0;
   logic [DUTY_W-1:0]   duty = '1;
   logic                ready, busy, done;
   logic [COUNT_W-1:0]  remaining;
   logic [2:0]          phase;
   logic [3:0]          coil;

   step_sequencer #(.PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W), .DUTY_W(DUTY_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .steps     (steps),
      .period    (period),
      .dir       (dir),
      .half_step (half_step),
      .abort     (abort),
      .hold      (hold),
      .duty      (duty),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .remaining (remaining),
      .phase     (phase),
      .coil      (coil)
   );

   always #5 clk = ~clk;

   // Reference model: move-level state, steps scheduled by elapsed cycles.
   int tbl [8] = '{1, 3, 2, 6, 4, 12, 8, 9};
   int m_run, m_phase, m_rem, m_period, m_dir, m_half, m_since, m_done, m_coil, m_pwm;
   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_run = 0; m_phase = 0; m_rem = 0; m_period = 1; m_dir = 0; m_half = 0;
      m_since = 0; m_done = 0; m_coil = 0; m_pwm = 0;
   endtask

   task automatic model_edge();
      int gate;
      gate   = PWM ? (m_pwm < int'(duty)) : 1;
      m_coil = ((m_run != 0 || hold) && gate != 0) ? tbl[m_phase] : 0;
      m_pwm  = (m_pwm + 1) % (1 << DUTY_W);
      m_done = 0;
      if (m_run == 0) begin
         if (start && steps != 0) begin
            m_run    = 1;
            m_rem    = int'(steps);
            m_period = (period == 0) ? 1 : int'(period);
            m_dir    = int'(dir);
            m_half   = int'(half_step);
            m_since  = 0;
         end
      end else begin
         m_since++;
         if (abort) begin
            m_run  = 0;
            m_done = 1;
         end else if (m_since % m_period == 0) begin
            m_phase = (m_phase + (m_dir != 0 ? 1 : -1) * (m_half != 0 ? 1 : 2) + 8) % 8;
            m_rem--;
            if (m_rem == 0) begin
               m_run  = 0;
               m_done = 1;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("ready", ready, m_run == 0);
      chk("busy", busy, m_run != 0);
      chk("done", done, m_done);
      chk("remaining", remaining, m_rem);
      chk("phase", phase, m_phase);
      chk("coil", coil, m_coil);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_remaining", remaining, 0);
      chk("rst_phase", phase, 0);
      chk("rst_coil", coil, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic move(input int s, input int p, input bit d, input bit h, input bit hd, input int ab);
      steps = COUNT_W'(s); period = PERIOD_W'(p); dir = d; half_step = h; hold = hd;
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int k = 1; k < 400 && m_run != 0; k++) begin
         abort = (k == ab);
         cycle();
      end
      abort = 1'b0;
      cycle();
      $display("move steps=%0d period=%0d dir=%0d half=%0d hold=%0d abort_at=%0d -> phase=%0d remaining=%0d",
               s, p, d, h, hd, ab, phase, remaining);
   endtask

   task automatic pwm_window(input int dv, input int exp_on);
      int on_cnt;
      on_cnt = 0;
      hold = 1'b1;
      duty = DUTY_W'(dv);
      for (int k = 0; k < 256; k++) begin
         cycle();
         if (coil != 4'b0000) on_cnt++;
      end
      chk("pwm_on_count", on_cnt, exp_on);
      $display("pwm window duty=%0d -> coil on %0d of 256 cycles", dv, on_cnt);
   endtask

   initial begin
      model_reset();
      do_reset();

      // Forward half steps, period 3, coils released afterwards.
      move(4, 3, 1'b1, 1'b1, 1'b0, 0);
      chk("t1_phase", phase, 4);
      chk("t1_coil_off", coil, 0);

      // Reverse full steps at period 0 from phase 0, hold keeps 0100 energised.
      do_reset();
      move(2, 0, 1'b0, 1'b0, 1'b1, 0);
      chk("t2_phase", phase, 4);
      chk("t2_coil_hold", coil, PWM ? m_coil : 4'b0100);

      // Abort on the third step edge.
      do_reset();
      move(10, 5, 1'b1, 1'b1, 1'b0, 15);
      chk("abort_phase", phase, 2);
      chk("abort_remaining", remaining, 8);
      chk("abort_ready", ready, 1);

      // Zero-step start is ignored.
      move(0, 2, 1'b1, 1'b1, 1'b0, 0);
      chk("zero_busy", busy, 0);

      // Start held high through done cycles: back-to-back moves.
      steps = 2; period = 2; dir = 1'b0; half_step = 1'b1; hold = 1'b0;
      start = 1'b1;
      for (int k = 0; k < 14; k++) cycle();
      start = 1'b0;
      for (int k = 0; k < 20 && m_run != 0; k++) cycle();
      cycle();
      $display("back-to-back moves -> phase=%0d", phase);

      pwm_window(64, PWM ? 64 : 256);
      pwm_window(0, PWM ? 0 : 256);
      duty = '1;

      for (int n = 0; n < 20; n++) begin
         int ab;
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
         duty = DUTY_W'($urandom_range(0, 255));
         move(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab);
      end

      // Reset mid-move once phase reaches 5.
      do_reset();
      steps = 7; period = 1; dir = 1'b1; half_step = 1'b1; hold = 1'b1;
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int k = 0; k < 5; k++) cycle();
      chk("pre_reset_phase", phase, 5);
      do_reset();
      $display("reset mid-move -> phase=%0d busy=%0d", phase, busy);
      hold = 1'b0;
      for (int k = 0; k < 4; k++) cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Parametrised bipolar stepper sequencer; the next generation of the fixed-duty PWM plus clock-divider pair on the motor pins. It accepts a move command (step count, direction, step mode, step period) over a ready/start handshake. It then advances an 8-entry coil phase table at the programmed rate, holding or releasing the coils at rest and optionally chopping coil drive with a programmable PWM duty. It sits between board-level control (buttons/host) and the four coil driver pins on `gp`.

## Interface
- `PERIOD_W`, 16: width of step-period field, in clk cycles per step
- `COUNT_W`, 16: width of step-count and remaining-count fields
- `DUTY_W`, 8: width of PWM duty and PWM counter
- `clk` in 1: sole clock, all state on rising edge
- `rst_n` in 1: reset, asynchronous assert, active low
- `start` in 1: move request; accepted when `start & ready`
- `steps` in COUNT_W: steps to move; sampled on accept
- `period` in PERIOD_W: clk cycles per step; sampled on accept; 0 treated as 1
- `dir` in 1: 1 = phase index increments, 0 = decrements; sampled on accept
- `half_step` in 1: 1 = index ±1 per step, 0 = index ±2; sampled on accept
- `abort` in 1: terminate running move
- `hold` in 1: 1 = energise current phase while idle, 0 = coils off while idle
- `duty` in DUTY_W: PWM on-count, live (not sampled)
- `ready` out 1: high in IDLE
- `busy` out 1: high in RUN
- `done` out 1: one-cycle pulse on move completion or abort
- `remaining` out COUNT_W: steps not yet taken
- `phase` out 3: current phase index
- `coil` out 4: {B-, A-, B+, A+} drive, registered

## Operation
- FSM states IDLE, RUN. IDLE→RUN on `start & ready & steps!=0`; `start` with `steps==0` is ignored (no `done`).
- On accept: latch dir/half_step/period (0→1); `remaining`←steps; tick counter←period-1.
- RUN: tick counter decrements each cycle; when 0: phase←phase±(half_step?1:2) mod 8, `remaining`−1, counter reloads period-1.
- Step that takes `remaining` 1→0: same edge state→IDLE, `done`=1 next cycle.
- `abort` in RUN: wins over a coincident step (no phase change); state→IDLE, `done` pulses, `remaining` frozen at its value. `abort` in IDLE: no effect.
- Phase table, index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001. Full-step from even index = wave drive, from odd = two-phase drive (parity preserved).
- `phase` persists across moves; only reset clears it.
- `coil` next value = table[phase] when (busy | hold), else 0000; then gated by PWM (see Configuration).

## Timing
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `remaining`=0, `phase`=0, `coil`=0000, tick and PWM counters 0.
- Accept at edge T: `busy`=1 after T; first phase change at edge T+period; subsequent steps every `period` edges.
- `coil` lags `phase` by one clock.
- Last step at edge E: `ready`=1 and `done`=1 after E; `start` in that cycle is accepted (back-to-back moves, no idle gap beyond one cycle).
- `rst_n` low mid-move: immediate return to reset values, including `phase`.
- `remaining` wraps never; it stops at 0.

## Configuration
- `STEPPER_PWM_EN` defined: free-running DUTY_W counter; coil bits forced 0 when counter >= `duty`. `duty`=0 → coils always off; duty = 2^DUTY_W−1 → off one cycle per PWM period.
- Undefined: no PWM counter; `coil` = ungated table value; `duty` port present but ignored.

## Structure
- Package `stepper_pkg`: FSM state enum, 8×4 phase table constant, coil bit-position constants.
- One sub-module `pwm_gen` (DUTY_W counter + compare, output `pwm_on`), instantiated only under `STEPPER_PWM_EN`.

## Test plan
- Reset then start, steps=4, period=3, dir=1, half_step=1, hold=0 → phase 0→1→2→3→4 at edges T+3,+6,+9,+12; `done` once; coil 0000 after.
- steps=2, period=0, dir=0, half_step=0, from phase 0 → phase 6 then 4 on consecutive edges; coil 0100 held with hold=1.
- steps=10, period=5, abort at 3rd step edge → phase advanced by 2 only, `remaining`=8, `done` pulse, `ready`=1.
- start with steps=0 → stays IDLE, no `done`; start asserted in `done` cycle → accepted, `busy` continuous except one cycle.
- `STEPPER_PWM_EN`, DUTY_W=8, duty=64, hold=1 → each coil bit high 64 of every 256 cycles; duty=0 → coil 0000.
- rst_n low mid-move at phase 5 → all outputs to reset values asynchronously; phase=0.
